// File: rtl/led_event_sequencer.sv
// Shares one status LED between NUM_SRC event sources; source k blinks k+1 times, then a gap.
// Define LED_SEQ_FIXED_PRIO_EN for a fixed-priority (lowest index wins) arbiter instead of round-robin.
module led_event_sequencer #(
    parameter int NUM_SRC    = 4,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int GAP_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         event_in,
    input  logic                       enable,
    output logic                       led_out,
    output logic                       busy,
    output logic [$clog2(NUM_SRC)-1:0] active_id,
    output logic [NUM_SRC-1:0]         pending_out
);

    localparam int ID_W    = $clog2(NUM_SRC);
    localparam int MAX_A   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int MAX_CYC = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [ID_W-1:0]    blinks_left;
    logic [ID_W-1:0]    grant_id;
    logic               found;
    logic               grant;
    logic [NUM_SRC-1:0] clr_mask;
`ifndef LED_SEQ_FIXED_PRIO_EN
    logic [ID_W-1:0]    rr_ptr;
`endif

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        int idx;
        idx      = 0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef LED_SEQ_FIXED_PRIO_EN
            idx = i;
`else
            idx = (int'(rr_ptr) + i) % NUM_SRC;
`endif
            if (!found && pending_out[idx]) begin
                found    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
        grant    = (state == ST_IDLE) && enable && found;
        clr_mask = grant ? (NUM_SRC'(1) << grant_id) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            counter     <= '0;
            blinks_left <= '0;
            led_out     <= 1'b0;
            busy        <= 1'b0;
            active_id   <= '0;
            pending_out <= '0;
`ifndef LED_SEQ_FIXED_PRIO_EN
            rr_ptr      <= '0;
`endif
        end else begin
            // Set is OR-ed after the clear, so a new event on the grant edge survives.
            pending_out <= (pending_out & ~clr_mask) | event_in;

            if (state != ST_IDLE && !enable) begin
                state   <= ST_IDLE;
                led_out <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (grant) begin
                            state       <= ST_ON;
                            led_out     <= 1'b1;
                            busy        <= 1'b1;
                            active_id   <= grant_id;
                            blinks_left <= grant_id;
                            counter     <= ON_LOAD;
`ifndef LED_SEQ_FIXED_PRIO_EN
                            rr_ptr      <= (int'(grant_id) == NUM_SRC - 1) ? '0 : grant_id + 1'b1;
`endif
                        end
                    end
                    ST_ON: begin
                        if (counter == '0) begin
                            led_out <= 1'b0;
                            if (blinks_left != '0) begin
                                state       <= ST_OFF;
                                counter     <= OFF_LOAD;
                                blinks_left <= blinks_left - 1'b1;
                            end else begin
                                state   <= ST_GAP;
                                counter <= GAP_LOAD;
                            end
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                    ST_OFF: begin
                        if (counter == '0) begin
                            state   <= ST_ON;
                            led_out <= 1'b1;
                            counter <= ON_LOAD;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (counter == '0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        led_out <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_event_sequencer.sv
// Self-checking bench for led_event_sequencer: vector table plus hand-written corner sequences,
// with a queue of expected grant IDs popped as each code starts.
module tb_led_event_sequencer;

    localparam int NUM_SRC = 4;
    localparam int ON      = 4;
    localparam int OFF     = 2;
    localparam int GAP     = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] event_in;
    logic       led_out;
    logic       busy;
    logic [1:0] active_id;
    logic [3:0] pending_out;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    typedef struct packed {
        logic           do_reset;
        logic [3:0]     ev;
        logic [2:0]     n;
        logic [3:0][1:0] ids;
    } vec_t;

    vec_t vecs[5];

    led_event_sequencer #(
        .NUM_SRC   (NUM_SRC),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .event_in   (event_in),
        .enable     (enable),
        .led_out    (led_out),
        .busy       (busy),
        .active_id  (active_id),
        .pending_out(pending_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        enable   = 1'b1;
        event_in = '0;
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Starts at an idle sample; the next edge must grant the ID at the head of the queue.
    task automatic wait_grant(input bit from_q, input logic [3:0] pend, output int k);
        int         n;
        logic [3:0] exp_pend;
        n = 0;
        do begin
            step();
            n++;
        end while (!busy && n < 50);
        check("grant_latency", n, 1);
        if (exp_q.size() == 0) begin
            check("queue_nonempty", 0, 1);
            k = 0;
        end else begin
            k = exp_q.pop_front();
        end
        exp_pend = pend;
        if (from_q) begin
            exp_pend = '0;
            for (int i = 0; i < exp_q.size(); i++) exp_pend = exp_pend | 4'(1 << exp_q[i]);
        end
        check("grant_id", int'(active_id), k);
        check("grant_led", int'(led_out), 1);
        check("grant_pending", int'(pending_out), int'(exp_pend));
    endtask

    // Measures one code from its grant sample until busy falls; mid_ev is pulsed on the first cycle.
    task automatic measure_code(input int k, input logic [3:0] mid_ev);
        int led_cnt;
        int busy_cnt;
        int n;
        led_cnt  = 0;
        busy_cnt = 0;
        n        = 0;
        while (busy && n < 100) begin
            if (led_out) led_cnt++;
            busy_cnt++;
            if (n == 0) event_in = mid_ev;
            step();
            event_in = '0;
            n++;
        end
        check("code_led_cycles", led_cnt, (k + 1) * ON);
        check("code_busy_cycles", busy_cnt, (k + 1) * ON + k * OFF + GAP);
    endtask

    initial begin
        int k;
        int highs;

        vecs[0] = '{1'b1, 4'b0100, 3'd1, {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[1] = '{1'b1, 4'b1111, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[2] = '{1'b0, 4'b0011, 3'd2, {2'd0, 2'd0, 2'd1, 2'd0}};
`ifdef LED_SEQ_FIXED_PRIO_EN
        vecs[3] = '{1'b0, 4'b1001, 3'd2, {2'd0, 2'd0, 2'd3, 2'd0}};
`else
        vecs[3] = '{1'b0, 4'b1001, 3'd2, {2'd0, 2'd0, 2'd0, 2'd3}};
`endif
        vecs[4] = '{1'b0, 4'b0110, 3'd2, {2'd0, 2'd0, 2'd2, 2'd1}};

        rst_n    = 1'b0;
        enable   = 1'b1;
        event_in = '0;
        #1;
        check("reset_led", int'(led_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_active_id", int'(active_id), 0);
        check("reset_pending", int'(pending_out), 0);

        // Table-driven codes
        for (int r = 0; r < 5; r++) begin
            if (vecs[r].do_reset) apply_reset();
            for (int j = 0; j < int'(vecs[r].n); j++) exp_q.push_back(int'(vecs[r].ids[j]));
            event_in = vecs[r].ev;
            step();
            event_in = '0;
            check("row_pending", int'(pending_out), int'(vecs[r].ev));
            check("row_idle", int'(busy), 0);
            for (int j = 0; j < int'(vecs[r].n); j++) begin
                wait_grant(1'b1, 4'b0000, k);
                measure_code(k, 4'b0000);
            end
        end

        // Set/clear collision on the grant edge
        apply_reset();
        exp_q.push_back(1);
        exp_q.push_back(1);
        event_in = 4'b0010;
        step();
        check("coll_pending", int'(pending_out), 4'b0010);
        wait_grant(1'b0, 4'b0010, k);
        event_in = '0;
        measure_code(k, 4'b0000);
        wait_grant(1'b0, 4'b0000, k);
        measure_code(k, 4'b0000);

        // Abort during the second ON of id 3
        apply_reset();
        exp_q.push_back(3);
        event_in = 4'b1000;
        step();
        event_in = '0;
        wait_grant(1'b0, 4'b0000, k);
        repeat (7) step();
        check("abort_second_on", int'(led_out), 1);
        enable = 1'b0;
        step();
        check("abort_led", int'(led_out), 0);
        check("abort_busy", int'(busy), 0);
        event_in = 4'b0001;
        step();
        event_in = '0;
        check("abort_pending", int'(pending_out), 4'b0001);
        repeat (3) step();
        check("abort_hold_off", int'(busy), 0);
        enable = 1'b1;
        exp_q.push_back(0);
        wait_grant(1'b0, 4'b0000, k);
        measure_code(k, 4'b0000);

        // Asynchronous reset mid-ON with pending 1010
        apply_reset();
        exp_q.push_back(1);
        event_in = 4'b0010;
        step();
        event_in = '0;
        wait_grant(1'b0, 4'b0000, k);
        event_in = 4'b1010;
        step();
        event_in = '0;
        check("areset_pre_pending", int'(pending_out), 4'b1010);
        check("areset_pre_led", int'(led_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_led", int'(led_out), 0);
        check("areset_busy", int'(busy), 0);
        check("areset_active_id", int'(active_id), 0);
        check("areset_pending", int'(pending_out), 0);
        step();
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy || led_out) highs++;
        end
        check("areset_quiet", highs, 0);
        exp_q.push_back(2);
        event_in = 4'b0100;
        step();
        event_in = '0;
        wait_grant(1'b1, 4'b0000, k);
        measure_code(k, 4'b0000);

        // Repeated 1010 events, re-pulsed during every code
        apply_reset();
        exp_q.push_back(1);
        event_in = 4'b1010;
        step();
        event_in = '0;
        check("rep_pending", int'(pending_out), 4'b1010);
        wait_grant(1'b0, 4'b1000, k);
        for (int i = 0; i < 4; i++) begin
            int         nxt;
            logic [3:0] pend;
            measure_code(k, 4'b1010);
`ifdef LED_SEQ_FIXED_PRIO_EN
            nxt  = 1;
            pend = 4'b1000;
`else
            nxt  = (k == 1) ? 3 : 1;
            pend = (k == 1) ? 4'b0010 : 4'b1000;
`endif
            exp_q.push_back(nxt);
            wait_grant(1'b0, pend, k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
